// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI command engine: power-up dummy clocks, CRC7-framed commands, R1 polling
// with timeout and an optional 4-byte R3/R7 tail. Everything runs on CLOCK50 with clock enables.
`timescale 1ns/1ps
module sd_spi_cmd_engine #(
    parameter int DIV_W        = 8,
    parameter int CLK_DIV_SLOW = 125,
    parameter int CLK_DIV_FAST = 2,
    parameter int INIT_BYTES   = 10,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    input  logic        FAST,
    input  logic        INIT_STB,
    input  logic        CMD_STB,
    input  logic [5:0]  CMD_INDEX,
    input  logic [31:0] CMD_ARG,
    input  logic        CMD_LONG,
    output logic        CMD_ACK,
    output logic        BUSY,
    output logic        RES_STB,
    output logic [7:0]  RES_R1,
    output logic [31:0] RES_DATA,
    output logic        RES_TIMEOUT,
    output logic        MOSI,
    input  logic        MISO,
    output logic        SCLK,
    output logic        CS
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DUMMY = 3'd1;
    localparam logic [2:0] SETUP = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] POLL  = 3'd4;
    localparam logic [2:0] EXT   = 3'd5;
    localparam logic [2:0] TRAIL = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    localparam logic [7:0] INIT_LAST = 8'(INIT_BYTES - 1);
    localparam logic [7:0] POLL_LAST = 8'(RESP_TIMEOUT - 1);

    logic [2:0]       state;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       byte_cnt;
    logic [5:0]       index_q;
    logic [31:0]      arg_q;
    logic             long_q;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic [7:0]       r1_w;
    logic [31:0]      data_w;
    logic             timeout_w;

    logic             shifting;
    logic             tick;
    logic [47:0]      frame;
    logic [2:0]       next_idx;
    logic [7:0]       next_tx;
    logic [DIV_W-1:0] div_sel;

    // CRC7, polynomial x^7+x^3+1, zero init, message MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] msg);
        logic [6:0] c;
        logic       fb;
        // NOTE: blocking assignments here are intentional; each loop step must see the previous one's result.
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = msg[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    always_comb begin
        // NOTE: next_tx gets a default before the conditional so no latch is inferred.
        next_tx  = 8'hFF;
        shifting = (state != IDLE) && (state != DONE);
        tick     = shifting && (div_cnt == div_q - DIV_W'(1));
        frame    = {2'b01, index_q, arg_q, crc7({2'b01, index_q, arg_q}), 1'b1};
        next_idx = byte_cnt[2:0] + 3'd1;
        div_sel  = FAST ? DIV_W'(CLK_DIV_FAST) : DIV_W'(CLK_DIV_SLOW);
        if (state == SEND && byte_cnt < 8'd5)
            next_tx = frame[{3'd5 - next_idx, 3'b000} +: 8];
    end

    always_ff @(posedge CLOCK50) begin
        if (RESET) begin
            state       <= IDLE;
            div_q       <= DIV_W'(CLK_DIV_SLOW);
            div_cnt     <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            index_q     <= '0;
            arg_q       <= '0;
            long_q      <= 1'b0;
            tx_sh       <= 8'hFF;
            rx_sh       <= 8'hFF;
            r1_w        <= 8'hFF;
            data_w      <= '0;
            timeout_w   <= 1'b0;
            CMD_ACK     <= 1'b0;
            BUSY        <= 1'b0;
            RES_STB     <= 1'b0;
            RES_R1      <= 8'hFF;
            RES_DATA    <= '0;
            RES_TIMEOUT <= 1'b0;
            MOSI        <= 1'b1;
            SCLK        <= 1'b0;
            CS          <= 1'b1;
        end else begin
            CMD_ACK <= 1'b0;
            RES_STB <= 1'b0;
            div_cnt <= (shifting && !tick) ? div_cnt + DIV_W'(1) : '0;

            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    if (INIT_STB) begin
                        state <= DUMMY;
                        BUSY  <= 1'b1;
                        div_q <= div_sel;
                        MOSI  <= 1'b1;
                        tx_sh <= 8'hFF;
                    end else if (CMD_STB) begin
                        state     <= SETUP;
                        CMD_ACK   <= 1'b1;
                        BUSY      <= 1'b1;
                        div_q     <= div_sel;
                        index_q   <= CMD_INDEX;
                        arg_q     <= CMD_ARG;
                        long_q    <= CMD_LONG;
                        data_w    <= '0;
                        timeout_w <= 1'b0;
                        r1_w      <= 8'hFF;
                        CS        <= 1'b0;
                        // Byte 0 is {01, index}: its first bit is always 0.
                        MOSI      <= 1'b0;
                        tx_sh     <= {1'b1, CMD_INDEX, 1'b1};
                    end
                end

                DONE: begin
                    state       <= IDLE;
                    RES_STB     <= 1'b1;
                    BUSY        <= 1'b0;
                    RES_R1      <= r1_w;
                    RES_DATA    <= data_w;
                    RES_TIMEOUT <= timeout_w;
                end

                default: begin
                    if (tick && !SCLK) begin
                        SCLK  <= 1'b1;
                        rx_sh <= {rx_sh[6:0], MISO};
                        if (state == SETUP)
                            state <= SEND;
                    end else if (tick) begin
                        SCLK <= 1'b0;
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            MOSI    <= tx_sh[7];
                            tx_sh   <= {tx_sh[6:0], 1'b1};
                        end else begin
                            // Byte boundary: start the next byte immediately, no SCLK gap.
                            bit_cnt  <= '0;
                            MOSI     <= next_tx[7];
                            tx_sh    <= {next_tx[6:0], 1'b1};
                            byte_cnt <= byte_cnt + 8'd1;
                            case (state)
                                DUMMY: begin
                                    if (byte_cnt == INIT_LAST) begin
                                        state <= IDLE;
                                        BUSY  <= 1'b0;
                                    end
                                end
                                SEND: begin
                                    if (byte_cnt == 8'd5) begin
                                        state    <= POLL;
                                        byte_cnt <= '0;
                                    end
                                end
                                POLL: begin
                                    if (!rx_sh[7]) begin
                                        r1_w     <= rx_sh;
                                        state    <= long_q ? EXT : TRAIL;
                                        byte_cnt <= '0;
                                    end else if (byte_cnt == POLL_LAST) begin
                                        r1_w      <= 8'hFF;
                                        timeout_w <= 1'b1;
                                        state     <= TRAIL;
                                    end
                                end
                                EXT: begin
                                    data_w <= {data_w[23:0], rx_sh};
                                    if (byte_cnt == 8'd3)
                                        state <= TRAIL;
                                end
                                TRAIL: begin
                                    CS    <= 1'b1;
                                    state <= DONE;
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Bench for sd_spi_cmd_engine: a byte-level SD card model drives MISO and logs MOSI,
// a scoreboard monitor checks each result against expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_sd_spi_cmd_engine;

    logic        CLOCK50 = 1'b0;
    logic        RESET = 1'b1;
    logic        FAST = 1'b0;
    logic        INIT_STB = 1'b0;
    logic        CMD_STB = 1'b0;
    logic [5:0]  CMD_INDEX = '0;
    logic [31:0] CMD_ARG = '0;
    logic        CMD_LONG = 1'b0;
    logic        MISO = 1'b1;
    logic        CMD_ACK, BUSY, RES_STB, RES_TIMEOUT, MOSI, SCLK, CS;
    logic [7:0]  RES_R1;
    logic [31:0] RES_DATA;

    sd_spi_cmd_engine #(
        .DIV_W(8), .CLK_DIV_SLOW(4), .CLK_DIV_FAST(2), .INIT_BYTES(10), .RESP_TIMEOUT(8)
    ) dut (
        .CLOCK50(CLOCK50), .RESET(RESET), .FAST(FAST), .INIT_STB(INIT_STB),
        .CMD_STB(CMD_STB), .CMD_INDEX(CMD_INDEX), .CMD_ARG(CMD_ARG), .CMD_LONG(CMD_LONG),
        .CMD_ACK(CMD_ACK), .BUSY(BUSY), .RES_STB(RES_STB), .RES_R1(RES_R1),
        .RES_DATA(RES_DATA), .RES_TIMEOUT(RES_TIMEOUT), .MOSI(MOSI), .MISO(MISO),
        .SCLK(SCLK), .CS(CS)
    );

    always #5 CLOCK50 = ~CLOCK50;

    typedef struct {
        logic [7:0]  r1;
        logic [31:0] data;
        logic        timeout;
        logic [47:0] frame;
        int          nbytes;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] mosi_log[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Card model and pin observers, all sampled on the falling CLOCK50 edge.
    logic       sclk_d = 1'b0, cs_d = 1'b1, busy_d = 1'b0;
    logic [7:0] rx_b = 8'hFF, cur = 8'hFF, cur_sh = 8'hFF;
    int         bit_i = 0, nrx = 0;
    int         dummy_rises = 0, dummy_bad = 0, ack_cnt = 0;
    int         phase_cnt = 0, ph_min = 1000, ph_max = 0;
    bit         meas_en = 1'b0, dummy_mode = 1'b0;

    always @(negedge CLOCK50) begin
        phase_cnt++;
        if (CMD_ACK) ack_cnt++;
        if (dummy_mode && BUSY && (!CS || !MOSI)) dummy_bad++;
        if (meas_en && SCLK != sclk_d) begin
            if (phase_cnt < ph_min) ph_min = phase_cnt;
            if (phase_cnt > ph_max) ph_max = phase_cnt;
        end
        if (SCLK != sclk_d || CS != cs_d || BUSY != busy_d) phase_cnt = 0;

        if (CS) begin
            bit_i  = 0;
            nrx    = 0;
            MISO   = 1'b1;
            cur_sh = 8'hFF;
            if (SCLK && !sclk_d) dummy_rises++;
        end else if (SCLK && !sclk_d) begin
            rx_b = {rx_b[6:0], MOSI};
            bit_i++;
            if (bit_i == 8) begin
                mosi_log.push_back(rx_b);
                nrx++;
                bit_i = 0;
            end
        end else if (!SCLK && sclk_d) begin
            if (bit_i == 0) begin
                cur    = (nrx >= 6 && resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
                MISO   = cur[7];
                cur_sh = {cur[6:0], 1'b1};
            end else begin
                MISO   = cur_sh[7];
                cur_sh = {cur_sh[6:0], 1'b1};
            end
        end
        sclk_d = SCLK;
        cs_d   = CS;
        busy_d = BUSY;
    end

    // Scoreboard monitor: every RES_STB pops one expectation.
    always @(negedge CLOCK50) begin
        if (RES_STB) begin
            exp_t        e;
            logic [47:0] af;
            int          tail_bad;
            check("res_stb_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e        = exp_q.pop_front();
                af       = '0;
                tail_bad = 0;
                for (int i = 0; i < 6; i++)
                    af = {af[39:0], (i < mosi_log.size()) ? mosi_log[i] : 8'h00};
                for (int i = 6; i < mosi_log.size(); i++)
                    if (mosi_log[i] != 8'hFF) tail_bad++;
                check("res_r1", 64'(RES_R1), 64'(e.r1));
                check("res_data", 64'(RES_DATA), 64'(e.data));
                check("res_timeout", 64'(RES_TIMEOUT), 64'(e.timeout));
                check("mosi_frame", 64'(af), 64'(e.frame));
                check("mosi_byte_count", 64'(mosi_log.size()), 64'(e.nbytes));
                check("mosi_tail_ff", 64'(tail_bad), 64'd0);
                check("busy_at_res_stb", 64'(BUSY), 64'd0);
                check("cs_at_res_stb", 64'(CS), 64'd1);
                mosi_log.delete();
            end
        end
    end

    task automatic wait_ack(input string name);
        for (int i = 0; i < 5000; i++) begin
            @(posedge CLOCK50);
            #1;
            if (CMD_ACK) break;
        end
        check(name, 64'(CMD_ACK), 64'd1);
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic lng);
        CMD_INDEX = idx;
        CMD_ARG   = arg;
        CMD_LONG  = lng;
        CMD_STB   = 1'b1;
        wait_ack("cmd_ack");
        CMD_STB = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20000; i++) begin
            @(negedge CLOCK50);
            if (!BUSY) break;
        end
        check(name, 64'(BUSY), 64'd0);
        @(negedge CLOCK50);
    endtask

    task automatic expect_res(input logic [7:0] r1, input logic [31:0] data, input logic to,
                              input logic [47:0] frame, input int nbytes);
        exp_t e;
        e.r1      = r1;
        e.data    = data;
        e.timeout = to;
        e.frame   = frame;
        e.nbytes  = nbytes;
        exp_q.push_back(e);
    endtask

    localparam logic [47:0] FRAME_CMD0 = 48'h40_00000000_95;
    localparam logic [47:0] FRAME_CMD8 = 48'h48_000001AA_87;

    initial begin
        repeat (3) @(posedge CLOCK50);
        #1;
        check("rst_cs", 64'(CS), 64'd1);
        check("rst_sclk", 64'(SCLK), 64'd0);
        check("rst_mosi", 64'(MOSI), 64'd1);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_cmd_ack", 64'(CMD_ACK), 64'd0);
        check("rst_res_stb", 64'(RES_STB), 64'd0);
        check("rst_res_r1", 64'(RES_R1), 64'hFF);
        check("rst_res_data", 64'(RES_DATA), 64'd0);
        check("rst_res_timeout", 64'(RES_TIMEOUT), 64'd0);
        RESET = 1'b0;
        @(posedge CLOCK50);
        #1;

        // Power-up dummy clocks in slow mode.
        dummy_mode  = 1'b1;
        meas_en     = 1'b1;
        ph_min      = 1000;
        ph_max      = 0;
        dummy_rises = 0;
        INIT_STB    = 1'b1;
        @(posedge CLOCK50);
        #1;
        INIT_STB = 1'b0;
        check("init_busy", 64'(BUSY), 64'd1);
        wait_idle("init_idle");
        check("init_rises", 64'(dummy_rises), 64'd80);
        check("init_phase_min", 64'(ph_min), 64'd4);
        check("init_phase_max", 64'(ph_max), 64'd4);
        check("init_cs_mosi_high", 64'(dummy_bad), 64'd0);
        check("init_no_frame", 64'(mosi_log.size()), 64'd0);
        dummy_mode = 1'b0;
        meas_en    = 1'b0;

        // CMD0, card answers FF then 01.
        resp_q = '{8'hFF, 8'h01};
        expect_res(8'h01, 32'h0, 1'b0, FRAME_CMD0, 9);
        send_cmd(6'd0, 32'h0, 1'b0);
        wait_idle("cmd0_idle");

        // CMD8 in fast mode with R7 tail.
        resp_q  = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        FAST    = 1'b1;
        meas_en = 1'b1;
        ph_min  = 1000;
        ph_max  = 0;
        expect_res(8'h01, 32'h000001AA, 1'b0, FRAME_CMD8, 12);
        send_cmd(6'd8, 32'h000001AA, 1'b1);
        FAST = 1'b0;
        wait_idle("cmd8_idle");
        check("fast_phase_min", 64'(ph_min), 64'd2);
        check("fast_phase_max", 64'(ph_max), 64'd2);
        meas_en = 1'b0;

        // MISO stuck high: 8 poll bytes, timeout, RES_DATA cleared even with CMD_LONG.
        resp_q.delete();
        expect_res(8'hFF, 32'h0, 1'b1, FRAME_CMD0, 15);
        send_cmd(6'd0, 32'h0, 1'b1);
        wait_idle("timeout_idle");

        // INIT and CMD in the same cycle: dummy clocks first, then the command.
        resp_q      = '{8'h01};
        dummy_rises = 0;
        ack_cnt     = 0;
        expect_res(8'h01, 32'h0, 1'b0, FRAME_CMD0, 8);
        CMD_INDEX = 6'd0;
        CMD_ARG   = 32'h0;
        CMD_LONG  = 1'b0;
        CMD_STB   = 1'b1;
        INIT_STB  = 1'b1;
        @(posedge CLOCK50);
        #1;
        INIT_STB = 1'b0;
        check("both_no_ack", 64'(CMD_ACK), 64'd0);
        check("both_busy", 64'(BUSY), 64'd1);
        wait_ack("both_late_ack");
        CMD_STB = 1'b0;
        check("both_dummy_first", 64'(dummy_rises), 64'd80);
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLOCK50);
            if (nrx >= 1) break;
        end
        @(posedge CLOCK50);
        #1;
        CMD_INDEX = 6'd8;
        CMD_STB   = 1'b1;
        @(posedge CLOCK50);
        #1;
        CMD_STB = 1'b0;
        wait_idle("both_idle");
        repeat (40) @(posedge CLOCK50);
        #1;
        check("busy_strobe_ignored_ack", 64'(ack_cnt), 64'd1);
        check("busy_strobe_ignored_busy", 64'(BUSY), 64'd0);

        // Reset during SEND byte 2 aborts without a result.
        resp_q.delete();
        send_cmd(6'd0, 32'h0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLOCK50);
            if (nrx >= 2) break;
        end
        check("abort_reached_byte2", 64'(nrx), 64'd2);
        RESET = 1'b1;
        @(posedge CLOCK50);
        #1;
        check("abort_cs", 64'(CS), 64'd1);
        check("abort_sclk", 64'(SCLK), 64'd0);
        check("abort_mosi", 64'(MOSI), 64'd1);
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_res_stb", 64'(RES_STB), 64'd0);
        RESET = 1'b0;
        mosi_log.delete();
        repeat (200) @(posedge CLOCK50);
        #1;
        check("abort_stays_idle", 64'(BUSY), 64'd0);

        resp_q = '{8'h01};
        expect_res(8'h01, 32'h0, 1'b0, FRAME_CMD0, 8);
        send_cmd(6'd0, 32'h0, 1'b0);
        wait_idle("post_abort_idle");

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_spi_cmd_engine.md
Name: sd_spi_cmd_engine

Overview:
- Parametrised SD-card SPI command engine; successor to the fixed CMD0-only card driver.
- Runs all logic on CLOCK50 using clock enables; no derived clocks.
- Provides power-up dummy clocking, arbitrary command frames with an internally computed CRC7, R1 polling with timeout, optional 4-byte R3/R7 tail, and run-time slow/fast SCLK selection.
- Sits between the card-init/host sequencer and the card pins.

Parameters:
- DIV_W, 8: width of the divider counter.
- CLK_DIV_SLOW, 125: CLOCK50 cycles per SCLK half-period in slow mode (200 kHz).
- CLK_DIV_FAST, 2: CLOCK50 cycles per SCLK half-period in fast mode (12.5 MHz).
- INIT_BYTES, 10: dummy bytes on INIT, giving 80 SCLK cycles, which is at least 74.
- RESP_TIMEOUT, 8: maximum polled bytes while waiting for R1 (Ncr).

Ports:
- CLOCK50  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- FAST  in  1  1 selects CLK_DIV_FAST; sampled when a request is accepted.
- INIT_STB  in  1  request power-up dummy clocks.
- CMD_STB  in  1  command request; held high until CMD_ACK.
- CMD_INDEX  in  6  command index.
- CMD_ARG  in  32  command argument.
- CMD_LONG  in  1  expect 4 extra response bytes (R3/R7).
- CMD_ACK  out  1  one-cycle pulse: command accepted.
- BUSY  out  1  engine not idle.
- RES_STB  out  1  one-cycle pulse: result valid.
- RES_R1  out  8  R1 byte.
- RES_DATA  out  32  extra response bytes, first byte received in [31:24].
- RES_TIMEOUT  out  1  R1 never arrived.
- MOSI  out  1  serial data to card.
- MISO  in  1  serial data from card.
- SCLK  out  1  SPI clock, mode 0.
- CS  out  1  card select, active low.

Behaviour:
- Reset values:
  - CS=1, SCLK=0, MOSI=1.
  - BUSY=0, CMD_ACK=0, RES_STB=0, RES_R1=8'hFF, RES_DATA=0, RES_TIMEOUT=0.
  - State IDLE.
- Reset mid-transfer aborts; the reset values appear on the first edge with RESET high. No RES_STB is generated.
- Divider:
  - A half-period tick fires every DIV cycles, where DIV is latched from FAST at acceptance.
  - While shifting, SCLK toggles on each tick and otherwise stays low.
  - MISO is sampled on the CLOCK50 edge that drives SCLK high.
  - MOSI updates when SCLK goes low; the first bit is driven at byte start.
  - Data is MSB first.
  - Bytes within a transaction are back-to-back with no SCLK gap.
- Acceptance (state IDLE only):
  - INIT_STB wins over CMD_STB when both are high in the same cycle; CMD_STB gets no ack and stays pending.
  - CMD_ACK pulses the cycle after CMD_STB is seen. CMD_INDEX, CMD_ARG and CMD_LONG are latched on that cycle. BUSY rises with CMD_ACK and stays high until the cycle of RES_STB.
  - Strobes while BUSY are ignored.
- States:
  - IDLE
  - DUMMY: CS=1, MOSI=1, INIT_BYTES×8 SCLK cycles, then IDLE. BUSY falls; no RES_STB.
  - SETUP: CS=0 for one half-period before the first SCLK rise.
  - SEND: 6 bytes.
    - Byte0 = {2'b01, CMD_INDEX}.
    - Bytes 1-4 = CMD_ARG, MSB byte first.
    - Byte5 = {CRC7, 1'b1}.
    - CRC7 uses polynomial x^7+x^3+1, init 0, over bytes 0-4.
  - POLL: MOSI=1 (sending 0xFF); each received byte is checked.
    - First byte with bit7=0 is R1 → EXT if CMD_LONG, else TRAIL.
    - After RESP_TIMEOUT bytes with bit7=1: RES_TIMEOUT=1, RES_R1=8'hFF → TRAIL.
  - EXT: 4 bytes shifted into RES_DATA, MOSI=1.
  - TRAIL: one 0xFF byte with CS=0 (Ncs), then CS=1 and SCLK=0.
  - DONE: RES_STB pulses one cycle, BUSY falls in the same cycle, then IDLE.
- Result registers:
  - RES_R1, RES_DATA and RES_TIMEOUT hold until the next command's RES_STB.
  - RES_DATA is cleared at acceptance; it stays 0 on timeout or when CMD_LONG=0.
- A new request may be accepted the cycle after RES_STB.

Test Plan:
- Reset, CLK_DIV_SLOW=4, INIT_STB pulse → exactly 80 SCLK rising edges, SCLK high and low phases of 4 CLOCK50 cycles each, CS=1 and MOSI=1 throughout, BUSY low afterwards, no RES_STB.
- CMD0 with arg 0x00000000; card returns FF then 01 → MOSI bytes 40 00 00 00 00 95; RES_R1=0x01, RES_TIMEOUT=0, RES_DATA=0; one trailing FF byte sent before CS rises.
- CMD8 with arg 0x000001AA, CMD_LONG=1, FAST=1; card returns 01 00 00 01 AA → frame 48 00 00 01 AA 87; SCLK half-period of 2 cycles; RES_R1=0x01, RES_DATA=0x000001AA.
- MISO stuck at 1 → exactly 8 POLL bytes, then RES_TIMEOUT=1, RES_R1=0xFF, RES_DATA=0, followed by the TRAIL byte and RES_STB.
- INIT_STB and CMD_STB high in the same idle cycle → dummy clocks run first, then CMD_ACK. A CMD_STB pulse during BUSY gets no CMD_ACK and causes no frame.
- RESET asserted during SEND byte 2 → next cycle CS=1, SCLK=0, MOSI=1, BUSY=0, no RES_STB; a following CMD0 completes normally.
